mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Initiator-side controller that drives the 512x8 byte-addressed, big-endian data RAM over its Enable/ReadWrite/OP/MOC handshake.
- Accepts one load/store request at a time from the CPU datapath and sequences the RAM strobes.
- Waits for MOC, then returns size-adjusted, sign- or zero-extended load data with a one-cycle done pulse.
- Checks alignment, range and timeout, so that bad requests never reach the RAM.

Parameters:
- MEM_BYTES, 512, RAM size in bytes; range-check limit.
- TIMEOUT, 16, maximum WAIT cycles without MOC before aborting; must be at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1=store, 0=load.
- cpu_size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- cpu_signed  in  1  for loads, 1=sign-extend, 0=zero-extend.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-justified.
- cpu_busy  out  1  high in every state except IDLE.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  load result; valid while cpu_done=1, held until the next done.
- cpu_err  out  2  00 ok, 01 misaligned/illegal size, 10 out of range, 11 timeout; valid with cpu_done.
- mem_enable  out  1  RAM Enable.
- mem_rw  out  1  RAM ReadWrite: 1=read, 0=write.
- mem_addr  out  32  RAM Address.
- mem_din  out  32  RAM DataIn.
- mem_op  out  6  RAM OP code.
- mem_dout  in  32  RAM DataOut.
- mem_moc  in  1  RAM memory-operation-complete.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, except mem_rw=1 (read, the benign level). cpu_rdata=0.
- On reset, an in-flight access is abandoned: mem_enable drops immediately and no done pulse is issued.
- OP codes:
  - Loads: word 001000, half 000010, byte 000001.
  - Stores: word 000100, half 000110, byte 000101.
- IDLE -> CHECK when cpu_req=1. All request fields are latched at that edge, and later changes are ignored until done.
- CHECK (1 cycle), error checks:
  - Size 11, half with addr[0]=1, or word with addr[1:0]!=00 -> err 01.
  - Otherwise, addr + bytes - 1 >= MEM_BYTES -> err 10, computed in 33 bits so there is no wrap.
  - On any error -> DONE, with no RAM activity.
  - On no error -> SETUP.
- SETUP (1 cycle):
  - Drive mem_addr, mem_din = latched wdata, mem_op and mem_rw, with mem_enable=0.
  - Guarantees a fresh rising Enable edge and a stable ReadWrite before the edge.
- WAIT:
  - mem_enable=1. mem_rw, mem_addr and mem_op are held constant, because a ReadWrite change while Enable is high retriggers the RAM.
  - Cycle counter cnt starts at 0 and increments each cycle.
  - mem_moc is ignored while cnt=0, since MOC from the previous access can still be high.
  - mem_moc=1 with cnt>=1 -> capture, go to DONE, err 00.
  - cnt reaches TIMEOUT-1 without MOC -> DONE, err 11.
- Load capture (at the MOC edge):
  - Word: rdata = mem_dout.
  - Half: rdata[15:0] = mem_dout[15:0]; upper 16 bits = sign bit mem_dout[15] if cpu_signed, else 0.
  - Byte: rdata[7:0] = mem_dout[7:0]; upper 24 bits = mem_dout[7] if cpu_signed, else 0.
  - Stores and errors leave cpu_rdata unchanged.
- DONE (1 cycle): mem_enable=0, cpu_done=1, cpu_err valid; then -> IDLE.
- A cpu_req held high in DONE is not accepted until IDLE, so back-to-back requests are at least 1 idle cycle apart.
- Latency, request edge E0 to cpu_done, with RAM MOC immediate:
  - E0 -> CHECK, E1 -> SETUP, E2 -> WAIT, E3 sees cnt=0, E4 sees MOC and goes to DONE.
  - cpu_done is high in the cycle after E4, i.e. 5 cycles.
  - Error paths take 2 cycles.

Decomposition:
- Package mem_pkg holds:
  - the six OP constants;
  - size encodings (SZ_BYTE/SZ_HALF/SZ_WORD);
  - error codes (ERR_OK/ERR_ALIGN/ERR_RANGE/ERR_TIMEOUT);
  - the state encoding (IDLE, CHECK, SETUP, WAIT, DONE).
- One combinational sub-module, load_extend (size, signed flag, 32-bit raw data -> 32-bit extended result), shared later with the writeback stage.

Test Plan:
- Store word 0xDEADBEEF at addr 0x10, then load word from 0x10 -> rdata=0xDEADBEEF, err=00, done 5 cycles after req; RAM bytes 0x10..0x13 = DE,AD,BE,EF.
- Load byte 0x11, signed -> 0xFFFFFFAD; unsigned -> 0x000000AD. Load half 0x12, signed -> 0xFFFFBEEF.
- Load half at 0x13 -> err=01 after 2 cycles, mem_enable never rises. Word at 0x1FE -> err=01. Word at 0x1FC -> ok. Byte at 0x200 -> err=10.
- RAM model withholds MOC with TIMEOUT=16 -> err=11 after 16 WAIT cycles, mem_enable low in DONE, cpu_rdata unchanged.
- Assert rst_n=0 during WAIT -> mem_enable and cpu_busy drop without waiting for a clock edge, no cpu_done; the next request completes normally.
- Stale MOC: leave mem_moc high from the previous access and delay the new MOC by 3 cycles -> capture happens on the new MOC only, and rdata holds the new data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-RAM access path: RAM OP codes, access
// size and error encodings, controller state encoding, and small helpers
// that map a request onto the RAM's view of it.
package mem_pkg;

   // RAM OP codes
   localparam logic [5:0] OP_LW = 6'b001000;
   localparam logic [5:0] OP_LH = 6'b000010;
   localparam logic [5:0] OP_LB = 6'b000001;
   localparam logic [5:0] OP_SW = 6'b000100;
   localparam logic [5:0] OP_SH = 6'b000110;
   localparam logic [5:0] OP_SB = 6'b000101;

   // Access sizes (2'b11 is illegal)
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Completion status
   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_ALIGN   = 2'b01;
   localparam logic [1:0] ERR_RANGE   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      SETUP = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   function automatic logic [5:0] op_code(input logic we, input logic [1:0] size);
      logic [5:0] op;
      case (size)
         SZ_BYTE: op = we ? OP_SB : OP_LB;
         SZ_HALF: op = we ? OP_SH : OP_LH;
         default: op = we ? OP_SW : OP_LW;
      endcase
      return op;
   endfunction

   function automatic logic [2:0] access_bytes(input logic [1:0] size);
      logic [2:0] n;
      case (size)
         SZ_BYTE: n = 3'd1;
         SZ_HALF: n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Load-data size adjustment: takes right-justified RAM read data and
// returns the byte/halfword/word result, sign- or zero-extended to 32 bits.
// Purely combinational so the writeback stage can reuse it.
//   size     : access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   sign_ext : 1 = sign-extend, 0 = zero-extend
//   raw      : RAM DataOut
//   ext      : extended 32-bit result
module load_extend
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;
   logic signed [31:0] byte_sx;
   logic signed [31:0] half_sx;

   assign byte_s  = $signed(raw[7:0]);
   assign half_s  = $signed(raw[15:0]);
   assign byte_sx = 32'(byte_s);
   assign half_sx = 32'(half_s);

   always_comb begin
      ext = raw;
      case (size)
         SZ_BYTE: ext = sign_ext ? byte_sx : {24'd0, raw[7:0]};
         SZ_HALF: ext = sign_ext ? half_sx : {16'd0, raw[15:0]};
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the 512x8 big-endian data RAM. Takes one
// load/store request at a time, rejects misaligned or out-of-range requests
// before the RAM sees them, sequences Enable/ReadWrite/OP, waits for MOC
// (with timeout) and returns extended load data with a one-cycle done pulse.
//   cpu_req/we/size/signed/addr/wdata : request, latched in IDLE
//   cpu_busy/done/rdata/err           : status and result
//   mem_enable/rw/addr/din/op         : RAM strobes and request
//   mem_dout/mem_moc                  : RAM response
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int MEM_BYTES = 512,
   parameter int TIMEOUT   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_size,
   input  logic        cpu_signed,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_busy,
   output logic        cpu_done,
   output logic [31:0] cpu_rdata,
   output logic [1:0]  cpu_err,
   output logic        mem_enable,
   output logic        mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic [5:0]  mem_op,
   input  logic [31:0] mem_dout,
   input  logic        mem_moc
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic               we_q, sgn_q;
   logic [1:0]         size_q;
   logic [31:0]        addr_q, wdata_q;
   logic [31:0]        rdata_q;
   logic [1:0]         err_q;
   logic [32:0]        last_byte;
   logic               align_err, range_err;
   logic               moc_ok, tmo;
   logic               drive;
   logic [31:0]        ext_data;

   // Checks run on the latched request during CHECK
   assign align_err = (size_q == 2'b11)
                    || ((size_q == SZ_HALF) && addr_q[0])
                    || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
   // 33-bit sum so a high address cannot wrap back into range
   assign last_byte = {1'b0, addr_q} + {30'd0, access_bytes(size_q)} - 33'd1;
   assign range_err = last_byte >= 33'(MEM_BYTES);

   // MOC in the first WAIT cycle may be left over from the previous access
   assign moc_ok = (cnt != '0) && mem_moc;
   assign tmo    = (cnt == CNT_W'(TIMEOUT - 1));

   load_extend u_ext (
      .size     (size_q),
      .sign_ext (sgn_q),
      .raw      (mem_dout),
      .ext      (ext_data)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (cpu_req) state_nx = CHECK;
         CHECK:   state_nx = (align_err || range_err) ? DONE : SETUP;
         SETUP:   state_nx = WAIT;
         WAIT:    if (moc_ok || tmo) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         err_q   <= ERR_OK;
         rdata_q <= '0;
      end else begin
         case (state)
            CHECK: begin
               cnt <= '0;
               if (align_err)      err_q <= ERR_ALIGN;
               else if (range_err) err_q <= ERR_RANGE;
               else                err_q <= ERR_OK;
            end
            WAIT: begin
               if (moc_ok) begin
                  err_q <= ERR_OK;
                  if (!we_q) rdata_q <= ext_data;
               end else if (tmo) begin
                  err_q <= ERR_TIMEOUT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Request fields are captured once and held until the access finishes
   always_ff @(posedge clk) begin
      if ((state == IDLE) && cpu_req) begin
         we_q    <= cpu_we;
         size_q  <= cpu_size;
         sgn_q   <= cpu_signed;
         addr_q  <= cpu_addr;
         wdata_q <= cpu_wdata;
      end
   end

   // RAM request is presented in SETUP and held unchanged through WAIT;
   // Enable only in WAIT so every access gets a fresh rising edge.
   assign drive      = (state == SETUP) || (state == WAIT);
   assign mem_enable = (state == WAIT);
   assign mem_rw     = drive ? ~we_q : 1'b1;
   assign mem_addr   = drive ? addr_q : '0;
   assign mem_din    = drive ? wdata_q : '0;
   assign mem_op     = drive ? op_code(we_q, size_q) : '0;

   assign cpu_busy   = (state != IDLE);
   assign cpu_done   = (state == DONE);
   assign cpu_rdata  = rdata_q;
   assign cpu_err    = err_q;

endmodule
